forward_ctrl: RTL and testbench

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_ctrl.sv | 117 +++++++++++
 tb/tb_forward_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/forward_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | forward_ctrl: EX-stage operand forwarding selects and load-use stall     |
// | Macro FORWARD_EN enables forwarding; undefined, hazards stall until WB.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module forward_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_store,
  input  logic [4:0] id_dest,
  input  logic       id_wb_en,
  input  logic       id_mem_r,
  output logic [1:0] alu_1_sel,
  output logic [1:0] alu_2_sel,
  output logic [1:0] st_data_sel,
  output logic       stall
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wb_en;
    logic       mem_r;
  } shadow_t;

  localparam int      c_ex     = 0;
  localparam int      c_mem    = 1;
  localparam int      c_wb     = 2;
  localparam shadow_t c_bubble = '{valid: 1'b0, dest: 5'd0, wb_en: 1'b0, mem_r: 1'b0};

  // Shadow copy of the instructions occupying EX, MEM and WB.
  shadow_t r_stage [0:2];

  function automatic logic is_cand(input logic valid, input logic wb_en,
                                   input logic [4:0] dest, input logic [4:0] r);
    return valid && wb_en && (dest == r) && (r != 5'd0);
  endfunction

  logic w_ex_rs, w_mem_rs, w_ex_rt, w_mem_rt, w_use_rt_any, w_hazard;

  assign w_ex_rs  = is_cand(r_stage[c_ex].valid,  r_stage[c_ex].wb_en,  r_stage[c_ex].dest,  id_rs);
  assign w_mem_rs = is_cand(r_stage[c_mem].valid, r_stage[c_mem].wb_en, r_stage[c_mem].dest, id_rs);
  assign w_ex_rt  = is_cand(r_stage[c_ex].valid,  r_stage[c_ex].wb_en,  r_stage[c_ex].dest,  id_rt);
  assign w_mem_rt = is_cand(r_stage[c_mem].valid, r_stage[c_mem].wb_en, r_stage[c_mem].dest, id_rt);
  assign w_use_rt_any = id_uses_rt | id_is_store;

`ifdef FORWARD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign w_hazard = r_stage[c_ex].mem_r &
                    ((id_uses_rs & w_ex_rs) | (w_use_rt_any & w_ex_rt));
`else
  assign w_hazard = (id_uses_rs & (w_ex_rs | w_mem_rs)) |
                    (w_use_rt_any & (w_ex_rt | w_mem_rt));
`endif

  assign stall = !rst && id_valid && w_hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage[c_ex]  <= c_bubble;
      r_stage[c_mem] <= c_bubble;
      r_stage[c_wb]  <= c_bubble;
    end else begin
      r_stage[c_wb]  <= r_stage[c_mem];
      r_stage[c_mem] <= r_stage[c_ex];
      if (id_valid && !stall) begin
        r_stage[c_ex] <= '{valid: 1'b1, dest: id_dest, wb_en: id_wb_en, mem_r: id_mem_r};
      end else begin
        r_stage[c_ex] <= c_bubble;
      end
    end
  end

`ifdef FORWARD_EN
  localparam logic [1:0] c_sel_def = 2'd0;
  localparam logic [1:0] c_sel_mem = 2'd1;
  localparam logic [1:0] c_sel_wb  = 2'd2;

  // The nearer producer (EX now, MEM next cycle) holds the newest value.
  function automatic logic [1:0] pick(input logic used, input logic ex_hit, input logic mem_hit);
    if (!used)        return c_sel_def;
    else if (ex_hit)  return c_sel_mem;
    else if (mem_hit) return c_sel_wb;
    else              return c_sel_def;
  endfunction

  logic [1:0] r_alu_1_sel, r_alu_2_sel, r_st_data_sel;

  always_ff @(posedge clk) begin
    if (rst || stall || !id_valid) begin
      r_alu_1_sel   <= c_sel_def;
      r_alu_2_sel   <= c_sel_def;
      r_st_data_sel <= c_sel_def;
    end else begin
      r_alu_1_sel   <= pick(id_uses_rs,  w_ex_rs, w_mem_rs);
      r_alu_2_sel   <= pick(id_uses_rt,  w_ex_rt, w_mem_rt);
      r_st_data_sel <= pick(id_is_store, w_ex_rt, w_mem_rt);
    end
  end

  assign alu_1_sel   = r_alu_1_sel;
  assign alu_2_sel   = r_alu_2_sel;
  assign st_data_sel = r_st_data_sel;
`else
  assign alu_1_sel   = 2'd0;
  assign alu_2_sel   = 2'd0;
  assign st_data_sel = 2'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_forward_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_forward_ctrl: directed self-checking bench for forward_ctrl           |
// | Expectations follow the FORWARD_EN setting of the build.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_forward_ctrl;

`ifdef FORWARD_EN
  localparam bit c_fwd = 1'b1;
`else
  localparam bit c_fwd = 1'b0;
`endif

  logic       clk, rst;
  logic       id_valid, id_uses_rs, id_uses_rt, id_is_store, id_wb_en, id_mem_r;
  logic [4:0] id_rs, id_rt, id_dest;
  logic [1:0] alu_1_sel, alu_2_sel, st_data_sel;
  logic       stall;

  int n_cmp = 0;
  int n_err = 0;

  forward_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_is_store (id_is_store),
    .id_dest     (id_dest),
    .id_wb_en    (id_wb_en),
    .id_mem_r    (id_mem_r),
    .alu_1_sel   (alu_1_sel),
    .alu_2_sel   (alu_2_sel),
    .st_data_sel (st_data_sel),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic st,
                       input logic [4:0] dest, input logic wb, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_store = st; id_dest = dest; id_wb_en = wb; id_mem_r = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    n_cmp++; if (alu_1_sel !== 2'd0) begin n_err++; $display("FAIL reset_alu1: got %0d want 0", alu_1_sel); end
    n_cmp++; if (alu_2_sel !== 2'd0) begin n_err++; $display("FAIL reset_alu2: got %0d want 0", alu_2_sel); end
    n_cmp++; if (st_data_sel !== 2'd0) begin n_err++; $display("FAIL reset_st: got %0d want 0", st_data_sel); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", stall); end
    rst = 1'b0;
  endtask

  task automatic test_alu_forward();
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0);   // add r3
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_prod_stall: got %0d want 0", stall); end
    tick();
    drive(1, 3, 4, 1, 1, 0, 6, 1, 0);   // add using rs=r3
    n_cmp++; if (stall !== !c_fwd) begin n_err++; $display("FAIL alu_cons_stall: got %0d want %0d", stall, !c_fwd); end
    tick();
    n_cmp++; if (alu_1_sel !== (c_fwd ? 2'd1 : 2'd0)) begin n_err++; $display("FAIL alu_fwd_sel1: got %0d want %0d", alu_1_sel, c_fwd ? 2'd1 : 2'd0); end
    n_cmp++; if (alu_2_sel !== 2'd0) begin n_err++; $display("FAIL alu_fwd_sel2: got %0d want 0", alu_2_sel); end
    n_cmp++; if (st_data_sel !== 2'd0) begin n_err++; $display("FAIL alu_fwd_st: got %0d want 0", st_data_sel); end
    n_cmp++; if (stall !== !c_fwd) begin n_err++; $display("FAIL alu_stall_2nd: got %0d want %0d", stall, !c_fwd); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall_3rd: got %0d want 0", stall); end
    flush();
  endtask

  task automatic test_store_wb();
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0);   // add r3
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);   // nop
    tick();
    drive(1, 7, 3, 1, 0, 1, 0, 0, 0);   // sw with rt=r3
    n_cmp++; if (stall !== !c_fwd) begin n_err++; $display("FAIL st_stall: got %0d want %0d", stall, !c_fwd); end
    tick();
    n_cmp++; if (st_data_sel !== (c_fwd ? 2'd2 : 2'd0)) begin n_err++; $display("FAIL st_sel: got %0d want %0d", st_data_sel, c_fwd ? 2'd2 : 2'd0); end
    n_cmp++; if (alu_2_sel !== 2'd0) begin n_err++; $display("FAIL st_alu2: got %0d want 0", alu_2_sel); end
    n_cmp++; if (alu_1_sel !== 2'd0) begin n_err++; $display("FAIL st_alu1: got %0d want 0", alu_1_sel); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL st_stall_after: got %0d want 0", stall); end
    flush();
  endtask

  task automatic test_load_use();
    drive(1, 1, 0, 1, 0, 0, 5, 1, 1);   // lw r5
    tick();
    drive(1, 5, 2, 1, 1, 0, 6, 1, 0);   // add with rs=r5
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0d want 1", stall); end
    tick();
    n_cmp++; if (alu_1_sel !== 2'd0) begin n_err++; $display("FAIL lu_bubble_sel: got %0d want 0", alu_1_sel); end
    n_cmp++; if (stall !== !c_fwd) begin n_err++; $display("FAIL lu_stall_2nd: got %0d want %0d", stall, !c_fwd); end
    tick();
    n_cmp++; if (alu_1_sel !== (c_fwd ? 2'd2 : 2'd0)) begin n_err++; $display("FAIL lu_wb_sel: got %0d want %0d", alu_1_sel, c_fwd ? 2'd2 : 2'd0); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_end: got %0d want 0", stall); end
    flush();
  endtask

  task automatic test_priority_r0();
    drive(1, 1, 2, 1, 1, 0, 4, 1, 0);   // add r4
    tick();
    drive(1, 1, 2, 1, 1, 0, 4, 1, 0);   // add r4 again
    tick();
    drive(1, 9, 4, 1, 1, 0, 7, 1, 0);   // use rt=r4
    n_cmp++; if (stall !== !c_fwd) begin n_err++; $display("FAIL prio_stall: got %0d want %0d", stall, !c_fwd); end
    tick();
    n_cmp++; if (alu_2_sel !== (c_fwd ? 2'd1 : 2'd0)) begin n_err++; $display("FAIL prio_sel: got %0d want %0d", alu_2_sel, c_fwd ? 2'd1 : 2'd0); end
    n_cmp++; if (alu_1_sel !== 2'd0) begin n_err++; $display("FAIL prio_alu1: got %0d want 0", alu_1_sel); end
    flush();
    drive(1, 1, 2, 1, 1, 0, 0, 1, 0);   // add r0
    tick();
    drive(1, 0, 0, 1, 1, 1, 8, 1, 0);   // use r0 everywhere
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL r0_stall: got %0d want 0", stall); end
    tick();
    n_cmp++; if (alu_1_sel !== 2'd0) begin n_err++; $display("FAIL r0_alu1: got %0d want 0", alu_1_sel); end
    n_cmp++; if (alu_2_sel !== 2'd0) begin n_err++; $display("FAIL r0_alu2: got %0d want 0", alu_2_sel); end
    n_cmp++; if (st_data_sel !== 2'd0) begin n_err++; $display("FAIL r0_st: got %0d want 0", st_data_sel); end
    flush();
    drive(1, 1, 0, 1, 0, 0, 0, 1, 1);   // lw r0
    tick();
    drive(1, 0, 0, 1, 1, 0, 8, 1, 0);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL r0_load_stall: got %0d want 0", stall); end
    flush();
  endtask

  task automatic test_gating();
    drive(1, 1, 0, 1, 0, 0, 5, 1, 1);   // lw r5
    tick();
    drive(1, 5, 5, 0, 0, 0, 6, 1, 0);   // names r5 but uses nothing
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL unused_stall: got %0d want 0", stall); end
    tick();
    n_cmp++; if (alu_1_sel !== 2'd0) begin n_err++; $display("FAIL unused_alu1: got %0d want 0", alu_1_sel); end
    n_cmp++; if (alu_2_sel !== 2'd0) begin n_err++; $display("FAIL unused_alu2: got %0d want 0", alu_2_sel); end
    flush();
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0);   // add r3
    tick();
    drive(0, 3, 3, 1, 1, 1, 6, 1, 0);   // bubble that would match r3
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL invalid_stall: got %0d want 0", stall); end
    tick();
    n_cmp++; if (alu_1_sel !== 2'd0) begin n_err++; $display("FAIL invalid_alu1: got %0d want 0", alu_1_sel); end
    n_cmp++; if (st_data_sel !== 2'd0) begin n_err++; $display("FAIL invalid_st: got %0d want 0", st_data_sel); end
    flush();
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 1, 0, 1, 0, 0, 5, 1, 1);   // lw r5
    tick();
    drive(1, 5, 2, 1, 1, 0, 6, 1, 0);   // add with rs=r5
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rms_stall: got %0d want 1", stall); end
    rst = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rms_stall_rst: got %0d want 0", stall); end
    tick();
    rst = 1'b0;
    n_cmp++; if (alu_1_sel !== 2'd0) begin n_err++; $display("FAIL rms_alu1: got %0d want 0", alu_1_sel); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rms_stall_after: got %0d want 0", stall); end
    tick();
    n_cmp++; if (alu_1_sel !== 2'd0) begin n_err++; $display("FAIL rms_use_sel: got %0d want 0", alu_1_sel); end
    flush();
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_store_wb();
    test_load_use();
    test_priority_r0();
    test_gating();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
